maquina_estados_mascota: RTL and testbench

MAQUINA_ESTADOS_MASCOTA -- requirements
Module: maquina_estados_mascota

---
 rtl/maquina_estados_mascota.sv | 149 ++++++++++++++
 tb/tb_maquina_estados_mascota.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/maquina_estados_mascota.sv
// Virtual pet controller: a 1-s tick timebase (shortened in test mode) paces
// evaluation of four need levels into a pet state with death after sustained neglect.
//
// state      | meaning
// NEUTRO     | no strong need, not all needs full
// FELIZ      | all four needs full
// HAMBRIENTO | energy low
// CANSADO    | rest low
// TRISTE     | mood low
// ENFERMO    | medicine low
// DORMIDO    | asleep after rest hit zero; waits for full rest
// MUERTO     | critical too long; only reset leaves
module maquina_estados_mascota #(
    parameter int CICLOS_SEG  = 50000000,
    parameter int CICLOS_TEST = 5000000,
    parameter int T_MUERTE    = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       test,
    input  logic [1:0] Nivel_Animo,
    input  logic [1:0] Nivel_Energia,
    input  logic [1:0] Nivel_Descanso,
    input  logic [1:0] Nivel_Medicina,
    output logic [2:0] estado,
    output logic       Activo_Comida,
    output logic       Activo_Medicina,
    output logic       modo_test,
    output logic       tick_seg
);

    localparam int CMAX = (CICLOS_SEG > CICLOS_TEST) ? CICLOS_SEG : CICLOS_TEST;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int KW   = $clog2(T_MUERTE + 1);

    typedef enum logic [2:0] {
        NEUTRO     = 3'd0,
        FELIZ      = 3'd1,
        HAMBRIENTO = 3'd2,
        CANSADO    = 3'd3,
        TRISTE     = 3'd4,
        ENFERMO    = 3'd5,
        DORMIDO    = 3'd6,
        MUERTO     = 3'd7
    } estado_t;

    estado_t       estado_q, estado_d, cand;
    logic [CW-1:0] cnt_q, cnt_d, periodo_m1;
    logic [KW-1:0] crit_q, crit_d;
    logic          tick_q, tick_d;
    logic          modo_q, modo_d;
    logic          comida_q, comida_d;
    logic          medic_q, medic_d;
    logic          crit_inc;

    always_comb begin
        periodo_m1 = modo_q ? CW'(CICLOS_TEST - 1) : CW'(CICLOS_SEG - 1);
        modo_d     = modo_q;
        if (cnt_q >= periodo_m1) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end else begin
            cnt_d  = cnt_q + CW'(1);
            tick_d = 1'b0;
        end
        // A test pulse restarts the timebase and swallows any coincident wrap.
        if (test) begin
            modo_d = ~modo_q;
            cnt_d  = '0;
            tick_d = 1'b0;
        end
    end

    always_comb begin
        if (Nivel_Medicina <= 2'd1)
            cand = ENFERMO;
        else if (Nivel_Energia <= 2'd1)
            cand = HAMBRIENTO;
        else if (Nivel_Descanso <= 2'd1)
            cand = CANSADO;
        else if (Nivel_Animo <= 2'd1)
            cand = TRISTE;
        else if (Nivel_Animo == 2'd3 && Nivel_Energia == 2'd3 &&
                 Nivel_Descanso == 2'd3 && Nivel_Medicina == 2'd3)
            cand = FELIZ;
        else
            cand = NEUTRO;

        // Zero rest is expected while asleep, so it does not count as neglect.
        crit_inc = (Nivel_Animo == 2'd0) || (Nivel_Energia == 2'd0) ||
                   (Nivel_Medicina == 2'd0) ||
                   ((Nivel_Descanso == 2'd0) && (estado_q != DORMIDO));

        crit_d   = crit_q;
        estado_d = estado_q;
        if (tick_q) begin
            if (!crit_inc)
                crit_d = '0;
            else if (crit_q < KW'(T_MUERTE))
                crit_d = crit_q + KW'(1);

            if (estado_q == MUERTO)
                estado_d = MUERTO;
            else if (crit_inc && crit_d == KW'(T_MUERTE))
                estado_d = MUERTO;
            else if (estado_q == DORMIDO) begin
                if (Nivel_Medicina <= 2'd1)
                    estado_d = ENFERMO;
                else if (Nivel_Descanso == 2'd3)
                    estado_d = cand;
                else
                    estado_d = DORMIDO;
            end else if (estado_q == CANSADO && Nivel_Descanso == 2'd0)
                estado_d = (cand == ENFERMO) ? ENFERMO : DORMIDO;
            else
                estado_d = cand;
        end

        comida_d = !(estado_d == DORMIDO || estado_d == MUERTO);
        medic_d  = (estado_d == ENFERMO);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            estado_q <= NEUTRO;
            cnt_q    <= '0;
            crit_q   <= '0;
            tick_q   <= 1'b0;
            modo_q   <= 1'b0;
            comida_q <= 1'b1;
            medic_q  <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            crit_q   <= crit_d;
            tick_q   <= tick_d;
            modo_q   <= modo_d;
            comida_q <= comida_d;
            medic_q  <= medic_d;
        end
    end

    assign estado          = estado_q;
    assign Activo_Comida   = comida_q;
    assign Activo_Medicina = medic_q;
    assign modo_test       = modo_q;
    assign tick_seg        = tick_q;

endmodule

// File: tb/tb_maquina_estados_mascota.sv
// Scoreboard bench for the pet controller: expected states are queued as levels are
// driven and compared one cycle after each tick; tick spacing and test-mode toggles checked directly.
module tb_maquina_estados_mascota;

    logic       clk = 1'b0;
    logic       reset;
    logic       test;
    logic [1:0] Nivel_Animo, Nivel_Energia, Nivel_Descanso, Nivel_Medicina;
    logic [2:0] estado;
    logic       Activo_Comida, Activo_Medicina, modo_test, tick_seg;

    maquina_estados_mascota #(
        .CICLOS_SEG (4),
        .CICLOS_TEST(2),
        .T_MUERTE   (3)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .test           (test),
        .Nivel_Animo    (Nivel_Animo),
        .Nivel_Energia  (Nivel_Energia),
        .Nivel_Descanso (Nivel_Descanso),
        .Nivel_Medicina (Nivel_Medicina),
        .estado         (estado),
        .Activo_Comida  (Activo_Comida),
        .Activo_Medicina(Activo_Medicina),
        .modo_test      (modo_test),
        .tick_seg       (tick_seg)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] NEUTRO = 3'd0, FELIZ = 3'd1, HAMBRIENTO = 3'd2, CANSADO = 3'd3,
                           TRISTE = 3'd4, ENFERMO = 3'd5, DORMIDO = 3'd6, MUERTO = 3'd7;

    typedef struct {
        logic [2:0] st;
        logic       com;
        logic       med;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;
    int   cyc    = 0;
    int   last_tick = 0;
    int   prev_tick = 0;
    int   c0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_chk++;
        if (got === expv)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, expv, $time);
    endtask

    function automatic exp_t mk(input logic [2:0] st);
        exp_t e;
        e.st  = st;
        e.com = !(st == DORMIDO || st == MUERTO);
        e.med = (st == ENFERMO);
        return e;
    endfunction

    task automatic set_lv(input logic [1:0] a, input logic [1:0] e,
                          input logic [1:0] d, input logic [1:0] m);
        Nivel_Animo    = a;
        Nivel_Energia  = e;
        Nivel_Descanso = d;
        Nivel_Medicina = m;
    endtask

    task automatic wait_tick();
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (tick_seg) seen = 1;
        end
        if (!seen) chk("tick_timeout", 0, 1);
        prev_tick = last_tick;
        last_tick = cyc;
    endtask

    task automatic tick_check(input string tag, input logic [2:0] st);
        exp_t e;
        exp_q.push_back(mk(st));
        wait_tick();
        @(negedge clk);
        e = exp_q.pop_front();
        chk({tag, "_estado"}, 32'(estado), 32'(e.st));
        chk({tag, "_comida"}, 32'(Activo_Comida), 32'(e.com));
        chk({tag, "_medic"}, 32'(Activo_Medicina), 32'(e.med));
    endtask

    task automatic pulse_test();
        test = 1'b1;
        @(negedge clk);
        test = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0;
        test  = 1'b0;
        set_lv(3, 3, 3, 3);
        repeat (2) @(negedge clk);
        chk("rst_estado", 32'(estado), 32'(NEUTRO));
        chk("rst_comida", 32'(Activo_Comida), 1);
        chk("rst_medic", 32'(Activo_Medicina), 0);
        chk("rst_modo", 32'(modo_test), 0);
        chk("rst_tick", 32'(tick_seg), 0);
        reset = 1'b1;

        tick_check("feliz1", FELIZ);
        tick_check("feliz2", FELIZ);
        chk("period_normal", 32'(last_tick - prev_tick), 4);

        // Sick and starving until death
        set_lv(3, 0, 3, 1);
        tick_check("enf1", ENFERMO);
        tick_check("enf2", ENFERMO);
        tick_check("muerto", MUERTO);
        set_lv(3, 3, 3, 3);
        tick_check("muerto_hold1", MUERTO);
        tick_check("muerto_hold2", MUERTO);
        pulse_test();
        chk("muerto_test_modo", 32'(modo_test), 1);
        chk("muerto_test_estado", 32'(estado), 32'(MUERTO));
        pulse_test();
        chk("muerto_test_modo_back", 32'(modo_test), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_muerto_estado", 32'(estado), 32'(NEUTRO));
        chk("rst_muerto_comida", 32'(Activo_Comida), 1);
        reset = 1'b1;

        // Tired, asleep, wake on full rest
        tick_check("b_feliz", FELIZ);
        set_lv(3, 3, 1, 3);
        tick_check("cansado", CANSADO);
        set_lv(3, 3, 0, 3);
        for (int i = 0; i < 4; i++) tick_check($sformatf("dormido%0d", i), DORMIDO);
        set_lv(3, 3, 2, 3);
        tick_check("dormido_d2", DORMIDO);
        set_lv(3, 3, 3, 3);
        tick_check("despierta", FELIZ);

        // Intermittent sadness never accumulates to death
        set_lv(0, 3, 3, 3);
        tick_check("triste0a", TRISTE);
        tick_check("triste0b", TRISTE);
        set_lv(1, 3, 3, 3);
        tick_check("triste1", TRISTE);
        set_lv(0, 3, 3, 3);
        tick_check("triste0c", TRISTE);
        tick_check("triste0d", TRISTE);
        set_lv(3, 1, 3, 3);
        tick_check("hambre", HAMBRIENTO);
        set_lv(2, 2, 2, 2);
        tick_check("neutro", NEUTRO);
        set_lv(3, 3, 3, 3);

        // Test mode entry, then toggle coincident with wrap
        pulse_test();
        c0 = cyc;
        chk("test_on_modo", 32'(modo_test), 1);
        chk("test_on_tick", 32'(tick_seg), 0);
        tick_check("test_t1", FELIZ);
        chk("test_first_tick", 32'(last_tick - c0), 2);
        tick_check("test_t2", FELIZ);
        chk("period_test", 32'(last_tick - prev_tick), 2);
        pulse_test();
        c0 = cyc;
        chk("coinc_modo", 32'(modo_test), 0);
        chk("coinc_tick", 32'(tick_seg), 0);
        tick_check("after_coinc", FELIZ);
        chk("after_coinc_gap", 32'(last_tick - c0), 4);

        // Reset wins over a simultaneous test pulse
        reset = 1'b0;
        test  = 1'b1;
        @(negedge clk);
        test  = 1'b0;
        chk("rst_vs_test_modo", 32'(modo_test), 0);
        chk("rst_vs_test_tick", 32'(tick_seg), 0);
        chk("rst_vs_test_estado", 32'(estado), 32'(NEUTRO));
        reset = 1'b1;
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
